// File: rtl/r3_xfer_ctrl.sv
// Parasite-side block-transfer sequencer for Tube register 3. One start command
// moves a counted block through the R3 FIFO in either direction, paced by the R3 flags.
module r3_xfer_ctrl #(
    parameter int SETTLE = 2
) (
    input  logic        p_phi2,
    input  logic        p_rst,
    input  logic        start,
    input  logic        dir,
    input  logic [15:0] count,
    input  logic        one_byte_mode,
    input  logic        abort,
    input  logic        src_valid,
    input  logic [7:0]  src_data,
    output logic        src_ready,
    output logic        dst_valid,
    output logic [7:0]  dst_data,
    input  logic        dst_ready,
    output logic        r3_select,
    output logic        r3_rdnw,
    output logic [7:0]  r3_wdata,
    input  logic [7:0]  r3_rdata,
    input  logic        r3_full,
    input  logic        r3_empty,
    input  logic        r3_avail,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [15:0] remaining
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_SETTLE = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);

    state_t      state_r, state_s;
    logic        dir_r, dir_s;
    logic        one_byte_r, one_byte_s;
    logic        second_r, second_s;
    logic        extra_r, extra_s;
    logic [2:0]  settle_cnt_r, settle_cnt_s;
    logic [15:0] remaining_r, remaining_s;
    logic [7:0]  dst_data_r, dst_data_s;
    logic [7:0]  r3_wdata_r, r3_wdata_s;
    logic        src_ready_r, src_ready_s;
    logic        dst_valid_r, dst_valid_s;
    logic        r3_select_r, r3_select_s;
    logic        r3_rdnw_r, r3_rdnw_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        aborted_r, aborted_s;
    logic        pad_s, more_s, go_s;

    // Pair-position qualifiers: a second byte with nothing left is a pad/discard
    always_comb begin
        pad_s  = !one_byte_r && second_r && (remaining_r == 16'd0);
        more_s = (remaining_r != 16'd0) || second_r;
    end

    // Go-condition from WAIT; the second byte of a pair skips the FIFO flags
    always_comb begin
        go_s = 1'b0;
        if (!dir_r) begin
            if (one_byte_r) begin
                go_s = !r3_full && src_valid;
            end else if (!second_r) begin
                go_s = r3_empty && (src_valid || pad_s);
            end else begin
                go_s = src_valid || pad_s;
            end
        end else begin
            if (one_byte_r || !second_r) begin
                go_s = r3_avail && dst_ready;
            end else begin
                go_s = dst_ready || pad_s;
            end
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        state_s      = state_r;
        dir_s        = dir_r;
        one_byte_s   = one_byte_r;
        second_s     = second_r;
        extra_s      = extra_r;
        settle_cnt_s = settle_cnt_r;
        remaining_s  = remaining_r;
        dst_data_s   = dst_data_r;
        r3_wdata_s   = r3_wdata_r;
        src_ready_s  = 1'b0;
        dst_valid_s  = 1'b0;
        r3_select_s  = 1'b0;
        r3_rdnw_s    = 1'b0;
        done_s       = 1'b0;
        aborted_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (start) begin
                    dir_s       = dir;
                    one_byte_s  = one_byte_mode;
                    remaining_s = count;
                    second_s    = 1'b0;
                    extra_s     = 1'b0;
                    if (count == 16'd0) begin
                        state_s = ST_FINISH;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_s   = ST_IDLE;
                    aborted_s = 1'b1;
                end else if (go_s) begin
                    state_s     = ST_ACCESS;
                    r3_select_s = 1'b1;
                    r3_rdnw_s   = dir_r;
                    extra_s     = pad_s;
                    if (!dir_r) begin
                        r3_wdata_s  = pad_s ? 8'h00 : src_data;
                        src_ready_s = !pad_s;
                    end else begin
                        r3_wdata_s = r3_wdata_r;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_ACCESS: begin
                if (abort) begin
                    state_s   = ST_IDLE;
                    aborted_s = 1'b1;
                end else begin
                    state_s      = ST_SETTLE;
                    settle_cnt_s = SETTLE_LAST;
                    second_s     = !one_byte_r && !second_r;
                    if (!extra_r) begin
                        remaining_s = remaining_r - 16'd1;
                        if (dir_r) begin
                            dst_data_s  = r3_rdata;
                            dst_valid_s = 1'b1;
                        end else begin
                            dst_data_s = dst_data_r;
                        end
                    end else begin
                        remaining_s = remaining_r;
                    end
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_s   = ST_IDLE;
                    aborted_s = 1'b1;
                end else if (settle_cnt_r == 3'd0) begin
                    if (more_s) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_FINISH;
                        done_s  = 1'b1;
                    end
                end else begin
                    settle_cnt_s = settle_cnt_r - 3'd1;
                end
            end
            ST_FINISH: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge p_phi2) begin
        if (p_rst) begin
            state_r      <= ST_IDLE;
            dir_r        <= 1'b0;
            one_byte_r   <= 1'b0;
            second_r     <= 1'b0;
            extra_r      <= 1'b0;
            settle_cnt_r <= 3'd0;
            remaining_r  <= 16'd0;
            dst_data_r   <= 8'h00;
            r3_wdata_r   <= 8'h00;
            src_ready_r  <= 1'b0;
            dst_valid_r  <= 1'b0;
            r3_select_r  <= 1'b0;
            r3_rdnw_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            aborted_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            dir_r        <= dir_s;
            one_byte_r   <= one_byte_s;
            second_r     <= second_s;
            extra_r      <= extra_s;
            settle_cnt_r <= settle_cnt_s;
            remaining_r  <= remaining_s;
            dst_data_r   <= dst_data_s;
            r3_wdata_r   <= r3_wdata_s;
            src_ready_r  <= src_ready_s;
            dst_valid_r  <= dst_valid_s;
            r3_select_r  <= r3_select_s;
            r3_rdnw_r    <= r3_rdnw_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            aborted_r    <= aborted_s;
        end
    end

    assign src_ready = src_ready_r;
    assign dst_valid = dst_valid_r;
    assign dst_data  = dst_data_r;
    assign r3_select = r3_select_r;
    assign r3_rdnw   = r3_rdnw_r;
    assign r3_wdata  = r3_wdata_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign aborted   = aborted_r;
    assign remaining = remaining_r;

endmodule
